// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 execute stage: instruction codes, ALU
// function codes, branch/move condition codes and the condition-code record.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alu_op_e;

    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_LE     = 4'h1;
    localparam logic [3:0] COND_L      = 4'h2;
    localparam logic [3:0] COND_E      = 4'h3;
    localparam logic [3:0] COND_NE     = 4'h4;
    localparam logic [3:0] COND_GE     = 4'h5;
    localparam logic [3:0] COND_G      = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // Branch/move condition from a function code and a set of flags.
    function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
        logic res;
        case (fn)
            COND_ALWAYS: res = 1'b1;
            COND_LE:     res = (cc.sf ^ cc.of) | cc.zf;
            COND_L:      res = cc.sf ^ cc.of;
            COND_E:      res = cc.zf;
            COND_NE:     res = ~cc.zf;
            COND_GE:     res = ~(cc.sf ^ cc.of);
            COND_G:      res = ~(cc.sf ^ cc.of) & ~cc.zf;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational 64-bit ALU computing b OP a together with the flags that
// result would set.
module y86_alu
    import y86_pkg::*;
(
    input  alu_op_e     op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    // Operation select and signed-overflow detection
    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        case (op)
            ALU_ADD: begin
                result = b + a;
                of     = (a[63] == b[63]) && (result[63] != a[63]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[63] != b[63]) && (result[63] != b[63]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: begin
                result = 64'd0;
                of     = 1'b0;
            end
        endcase
        zf = (result == 64'd0);
        sf = result[63];
    end

endmodule

// File: rtl/y86_execute.sv
// Y86-64 execute stage: operand selection into a shared ALU, the condition
// code register updated by OPq, and the cmov/jump condition evaluation.
module y86_execute
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [63:0] valE,
    output logic        cnd,
    output logic        ZF,
    output logic        SF,
    output logic        OF
);

    alu_op_e     alu_op_s;
    logic [63:0] alu_a_s;
    logic [63:0] alu_result_s;
    cc_t         alu_cc_s;
    logic        cc_load_s;
    cc_t         cc_r;

    // Only the four defined OPq functions touch the flags
    assign cc_load_s = (icode == ICODE_OPQ) && (ifun <= 4'd3);

    // ALU operand/function selection; address and stack ops reuse the adder
    always_comb begin
        alu_op_s = ALU_ADD;
        alu_a_s  = valA;
        case (icode)
            ICODE_RMMOVQ, ICODE_MRMOVQ: begin
                alu_op_s = ALU_ADD;
                alu_a_s  = valC;
            end
            ICODE_OPQ: begin
                if (cc_load_s) begin
                    alu_op_s = alu_op_e'(ifun);
                end else begin
                    alu_op_s = ALU_ADD;
                end
                alu_a_s = valA;
            end
            ICODE_CALL, ICODE_PUSHQ: begin
                alu_op_s = ALU_SUB;
                alu_a_s  = 64'd8;
            end
            ICODE_RET, ICODE_POPQ: begin
                alu_op_s = ALU_ADD;
                alu_a_s  = 64'd8;
            end
            default: begin
                alu_op_s = ALU_ADD;
                alu_a_s  = valA;
            end
        endcase
    end

    y86_alu u_alu (
        .op     (alu_op_s),
        .a      (alu_a_s),
        .b      (valB),
        .result (alu_result_s),
        .zf     (alu_cc_s.zf),
        .sf     (alu_cc_s.sf),
        .of     (alu_cc_s.of)
    );

    // valE selection by instruction class
    always_comb begin
        valE = 64'd0;
        case (icode)
            ICODE_CMOVXX: valE = valA;
            ICODE_IRMOVQ: valE = valC;
            ICODE_RMMOVQ, ICODE_MRMOVQ,
            ICODE_CALL, ICODE_PUSHQ,
            ICODE_RET, ICODE_POPQ: valE = alu_result_s;
            ICODE_OPQ: begin
                if (cc_load_s) begin
                    valE = alu_result_s;
                end else begin
                    valE = 64'd0;
                end
            end
            default: valE = 64'd0;
        endcase
    end

    // Condition output, only meaningful for cmov and jumps
    always_comb begin
        cnd = 1'b0;
        if ((icode == ICODE_CMOVXX) || (icode == ICODE_JXX)) begin
            cnd = cond_eval(ifun, cc_r);
        end else begin
            cnd = 1'b0;
        end
    end

    // Condition-code register; reset wins over a coincident clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_r <= CC_RESET;
        end else if (cc_load_s) begin
            cc_r <= alu_cc_s;
        end else begin
            cc_r <= cc_r;
        end
    end

    assign ZF = cc_r.zf;
    assign SF = cc_r.sf;
    assign OF = cc_r.of;

endmodule

// File: tb/tb_y86_execute.sv
// Scoreboard bench for y86_execute: the driver queues hand-computed results
// per vector and a negedge monitor compares whatever the DUT presents.
module tb_y86_execute;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        ZF;
    logic        SF;
    logic        OF;

    int n_checks = 0;
    int n_fails  = 0;
    int vec_id   = 0;

    typedef struct {
        int          id;
        logic [63:0] vale;
        logic        cnd;
        logic        zf;
        logic        sf;
        logic        of;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    y86_execute dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .ifun  (ifun),
        .valA  (valA),
        .valB  (valB),
        .valC  (valC),
        .valE  (valE),
        .cnd   (cnd),
        .ZF    (ZF),
        .SF    (SF),
        .OF    (OF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector just after a rising edge and queue its expected response.
    // e_z/e_s/e_o are the flags visible during this cycle (before its own update).
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] e_vale, input logic e_cnd,
                         input logic e_z, input logic e_s, input logic e_o);
        exp_t e;
        @(posedge clk);
        #1;
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        vec_id++;
        e.id = vec_id; e.vale = e_vale; e.cnd = e_cnd; e.zf = e_z; e.sf = e_s; e.of = e_o;
        sb.push_back(e);
    endtask

    task automatic check_flags(input string name, input logic z, input logic s, input logic o);
        n_checks++;
        if ({ZF, SF, OF} !== {z, s, o}) begin
            n_fails++;
            $display("FAIL %s: got ZF/SF/OF=%b%b%b, expected %b%b%b", name, ZF, SF, OF, z, s, o);
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({valE, cnd, ZF, SF, OF} !== {e.vale, e.cnd, e.zf, e.sf, e.of}) begin
                n_fails++;
                $display("FAIL vec%0d: got valE=%h cnd=%b ZF/SF/OF=%b%b%b, expected valE=%h cnd=%b ZF/SF/OF=%b%b%b",
                         e.id, valE, cnd, ZF, SF, OF, e.vale, e.cnd, e.zf, e.sf, e.of);
            end
        end
    end

    initial begin
        reset = 1'b1; icode = 4'h1; ifun = 4'h0; valA = 64'd0; valB = 64'd0; valC = 64'd0;
        #1;
        check_flags("reset_init", 1'b1, 1'b0, 1'b0);
        #11;
        reset = 1'b0;

        //     icode ifun valA          valB          valC            valE                     cnd   Z     S     O
        drive(4'h1, 4'h0, 64'd9,        64'd9,        64'd9,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, 64'd5,        64'd7,        64'd0,          64'd12,                  1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h0, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b0, 1'b0, 1'b0);
        drive(4'h7, 4'h3, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'h6, 4'h1, 64'd7,        64'd7,        64'd0,          64'd0,                   1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'h7, 4'h3, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h4, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h1, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h0, MAXP,         MAXP,         64'd0,          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h2, 4'h2, 64'h1234,     64'd0,        64'd0,          64'h1234,                1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'h2, 4'h5, 64'h1234,     64'd0,        64'd0,          64'h1234,                1'b1, 1'b0, 1'b1, 1'b1);
        drive(4'h2, 4'h6, 64'h55,       64'd0,        64'd0,          64'h55,                  1'b1, 1'b0, 1'b1, 1'b1);
        drive(4'h4, 4'h0, 64'd3,        64'h20,       64'h10,         64'h30,                  1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'hA, 4'h0, 64'd3,        64'h100,      64'd0,          64'hF8,                  1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'h8, 4'h0, 64'd3,        64'h100,      64'd0,          64'hF8,                  1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'h9, 4'h0, 64'd3,        64'h100,      64'd0,          64'h108,                 1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'hB, 4'h0, 64'd3,        64'h100,      64'd0,          64'h108,                 1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'h3, 4'h0, 64'd3,        64'd5,        64'd42,         64'd42,                  1'b0, 1'b0, 1'b1, 1'b1);
        drive(4'h5, 4'h0, 64'd3,        64'h100,      64'hFFFF_FFFF_FFFF_FFF8, 64'hF8,         1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges discards SF=1/OF=1 immediately
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_flags("reset_async", 1'b1, 1'b0, 1'b0);
        #1;
        reset = 1'b0;

        drive(4'h6, 4'h1, 64'd1,        64'd0,        64'd0,          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h2, 64'hF0,       64'h0F,       64'd0,          64'd0,                   1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'h3, 4'h0, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h7, 64'd1,        64'd2,        64'd0,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h3, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b1, 1'b0, 1'b0);
        drive(4'hF, 4'h0, 64'd1,        64'd2,        64'd3,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h6, 4'h3, MINN,         64'd1,        64'd0,          64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h7, 4'h2, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b0, 1'b1, 1'b0);
        drive(4'h7, 4'h7, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'h6, 4'h1, 64'd1,        MINN,         64'd0,          MAXP,                    1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'h7, 4'h1, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b1, 1'b0, 1'b0, 1'b1);
        drive(4'h7, 4'h5, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b0, 1'b0, 1'b1);
        drive(4'h6, 4'h0, MINN,         MINN,         64'd0,          64'd0,                   1'b0, 1'b0, 1'b0, 1'b1);
        drive(4'h7, 4'h6, 64'd0,        64'd0,        64'd0,          64'd0,                   1'b0, 1'b1, 1'b0, 1'b1);
        drive(4'h2, 4'h0, 64'h77,       64'd0,        64'd0,          64'h77,                  1'b1, 1'b1, 1'b0, 1'b1);

        // Let the monitor drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5; i++) begin
            if (sb.size() > 0) begin
                @(posedge clk);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
